// File: rtl/exc_vector_fetch.sv
// exc_vector_fetch: exception-entry sequencer for the multicycle datapath.
// When an exception event arrives, the sequencer saves EPC and reads the
// vector byte from the fixed slot for that cause (253/254/255). It then loads
// the zero-extended byte into PC. If memory never acknowledges, it loads
// FALLBACK_PC instead.
// Optional feature macro: EXC_CAUSE_EN adds the exc_cause and exc_lost outputs.
module exc_vector_fetch #(
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter logic [31:0] FALLBACK_PC = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [2:0]  iordmux,
  output logic        mem_req,
  output logic        epc_write,
  output logic [31:0] epc_out,
  output logic        pc_load,
  output logic [31:0] pc_next,
  output logic        busy,
  output logic        timeout
`ifdef EXC_CAUSE_EN
  ,
  output logic [1:0]  exc_cause,
  output logic        exc_lost
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_REQ,
    S_WAIT,
    S_LOAD
  } state_t;

  // The counter holds (WAIT cycles elapsed - 1), so the last allowed cycle
  // is reached when it equals ACK_TIMEOUT-1.
  localparam logic [7:0] LAST_WAIT = 8'(ACK_TIMEOUT - 1);

  state_t      state;
  state_t      state_n;
  logic [2:0]  vecsel;
  logic [7:0]  waitcnt;
  logic        any_exc;
  logic [2:0]  vecsel_n;
  logic        take_exc;
  logic        ack_hit;
  logic        tmo_hit;
  logic        unused_rdata;

  assign any_exc = exc_opcode | exc_overflow | exc_divzero;

  // Only the low byte of the vector word is used.
  assign unused_rdata = ^mem_rdata[31:8];

  // Encode the highest-priority pending cause as its vector slot select code.
  always_comb begin
    vecsel_n = 3'b101;
    if (exc_opcode) begin
      vecsel_n = 3'b011;
    end else if (exc_overflow) begin
      vecsel_n = 3'b100;
    end
  end

  // State register; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic plus the capture strobes for the datapath registers.
  always_comb begin
    state_n  = state;
    take_exc = 1'b0;
    ack_hit  = 1'b0;
    tmo_hit  = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_exc) begin
          take_exc = 1'b1;
          state_n  = S_SAVE;
        end
      end
      S_SAVE: state_n = S_REQ;
      S_REQ:  state_n = S_WAIT;
      S_WAIT: begin
        if (mem_ack) begin
          ack_hit = 1'b1;
          state_n = S_LOAD;
        end else if (waitcnt == LAST_WAIT) begin
          tmo_hit = 1'b1;
          state_n = S_LOAD;
        end
      end
      S_LOAD:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Count cycles spent in WAIT; the count restarts from zero on every entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitcnt <= 8'd0;
    end else if (state == S_WAIT) begin
      waitcnt <= waitcnt + 8'd1;
    end else begin
      waitcnt <= 8'd0;
    end
  end

  // Latch the cause and the EPC value at the edge that accepts the event.
  // The latched values then appear during SAVE without any input-to-output path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vecsel  <= 3'b000;
      epc_out <= 32'd0;
    end else if (take_exc) begin
      vecsel  <= vecsel_n;
      epc_out <= pc_in - 32'd4;
    end
  end

  // Capture the new PC: the vector byte on ack, or the fallback on timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_next <= 32'd0;
      timeout <= 1'b0;
    end else begin
      timeout <= tmo_hit;
      if (ack_hit) begin
        pc_next <= {24'b0, mem_rdata[7:0]};
      end else if (tmo_hit) begin
        pc_next <= FALLBACK_PC;
      end
    end
  end

  // Strobes and the memory handshake are decoded from the state alone.
  always_comb begin
    busy      = (state != S_IDLE);
    epc_write = (state == S_SAVE);
    pc_load   = (state == S_LOAD);
    mem_req   = (state == S_REQ) || (state == S_WAIT);
    iordmux   = mem_req ? vecsel : 3'b000;
  end

`ifdef EXC_CAUSE_EN
  // Remember the accepted cause and flag any event that arrives while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exc_cause <= 2'b00;
      exc_lost  <= 1'b0;
    end else begin
      exc_lost <= busy & any_exc;
      if (take_exc) begin
        exc_cause <= exc_opcode ? 2'b01 : (exc_overflow ? 2'b10 : 2'b11);
      end
    end
  end
`endif

endmodule

// File: tb/tb_exc_vector_fetch.sv
// Testbench for exc_vector_fetch: directed cases followed by random sequences.
// Each cycle's outputs are compared against a timeline derived from the event
// and the cycle at which memory acknowledges.
// Define EXC_CAUSE_EN to also check the exc_cause/exc_lost outputs.
module tb_exc_vector_fetch;

  localparam int          ACK_TO   = 15;
  localparam logic [31:0] FALLBACK = 32'h0000_1F00;

  logic        clk;
  logic        reset;
  logic        excOpcode;
  logic        excOverflow;
  logic        excDivzero;
  logic [31:0] pcIn;
  logic [31:0] memRdata;
  logic        memAck;
  logic [2:0]  iordmux;
  logic        memReq;
  logic        epcWrite;
  logic [31:0] epcOut;
  logic        pcLoad;
  logic [31:0] pcNext;
  logic        busy;
  logic        timeoutPulse;
`ifdef EXC_CAUSE_EN
  logic [1:0]  excCause;
  logic        excLost;
`endif

  int checks = 0;
  int errors = 0;

  exc_vector_fetch #(
    .ACK_TIMEOUT(ACK_TO),
    .FALLBACK_PC(FALLBACK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .exc_opcode   (excOpcode),
    .exc_overflow (excOverflow),
    .exc_divzero  (excDivzero),
    .pc_in        (pcIn),
    .mem_rdata    (memRdata),
    .mem_ack      (memAck),
    .iordmux      (iordmux),
    .mem_req      (memReq),
    .epc_write    (epcWrite),
    .epc_out      (epcOut),
    .pc_load      (pcLoad),
    .pc_next      (pcNext),
    .busy         (busy),
    .timeout      (timeoutPulse)
`ifdef EXC_CAUSE_EN
    ,
    .exc_cause    (excCause),
    .exc_lost     (excLost)
`endif
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, ".busy"},      32'(busy),         32'd0);
    checkOutput({tag, ".iordmux"},   32'(iordmux),      32'd0);
    checkOutput({tag, ".mem_req"},   32'(memReq),       32'd0);
    checkOutput({tag, ".epc_write"}, 32'(epcWrite),     32'd0);
    checkOutput({tag, ".pc_load"},   32'(pcLoad),       32'd0);
    checkOutput({tag, ".timeout"},   32'(timeoutPulse), 32'd0);
  endtask

  // Run one exception sequence. exc is {opcode, overflow, divzero}.
  // Memory acks in WAIT cycle ackAt; any ackAt beyond ACK_TO means memory never acks.
  // Called at #1 after a rising edge with the DUT idle.
  task automatic applyStimulus(input logic [2:0] exc, input logic [31:0] pc,
                               input logic [31:0] rdata, input int ackAt, input bit noisy);
    bit          tmo;
    int          waitCycles;
    int          last;
    logic [2:0]  code;
    logic [31:0] expPc;
    logic [31:0] expEpc;
    logic [1:0]  expCause;
    logic [2:0]  noise;
    logic [2:0]  prevNoise;
    tmo        = (ackAt > ACK_TO);
    waitCycles = tmo ? ACK_TO : ackAt;
    last       = 3 + waitCycles;
    code       = exc[2] ? 3'b011 : (exc[1] ? 3'b100 : 3'b101);
    expCause   = exc[2] ? 2'b01 : (exc[1] ? 2'b10 : 2'b11);
    expPc      = tmo ? FALLBACK : {24'h0, rdata[7:0]};
    expEpc     = pc - 32'd4;
    excOpcode   = exc[2];
    excOverflow = exc[1];
    excDivzero  = exc[0];
    pcIn        = pc;
    memRdata    = $urandom;
    memAck      = 1'($urandom_range(0, 1));
    prevNoise   = 3'b000;
    @(posedge clk); #1;
    for (int j = 1; j <= last + 1; j++) begin
      checkOutput("busy",      32'(busy),         32'(j <= last));
      checkOutput("epc_write", 32'(epcWrite),     32'(j == 1));
      checkOutput("mem_req",   32'(memReq),       32'(j >= 2 && j <= last - 1));
      checkOutput("iordmux",   32'(iordmux),      (j >= 2 && j <= last - 1) ? 32'(code) : 32'd0);
      checkOutput("pc_load",   32'(pcLoad),       32'(j == last));
      checkOutput("timeout",   32'(timeoutPulse), 32'(j == last && tmo));
      if (j == 1) checkOutput("epc_out", epcOut, expEpc);
      if (j == last) checkOutput("pc_next", pcNext, expPc);
      if (j == last + 1) begin
        checkOutput("pc_next_hold", pcNext, expPc);
        checkOutput("epc_out_hold", epcOut, expEpc);
      end
`ifdef EXC_CAUSE_EN
      checkOutput("exc_cause", 32'(excCause), 32'(expCause));
      checkOutput("exc_lost",  32'(excLost),  32'(prevNoise != 3'b000));
`endif
      noise       = (noisy && j < last) ? 3'($urandom_range(1, 7)) : 3'b000;
      excOpcode   = noise[2];
      excOverflow = noise[1];
      excDivzero  = noise[0];
      pcIn        = $urandom;
      memRdata    = (j == 2 + ackAt) ? rdata : $urandom;
      if (j >= 3 && j <= last - 1) memAck = (j == 2 + ackAt);
      else if (j == last + 1)      memAck = 1'b0;
      else                         memAck = 1'($urandom_range(0, 1));
      prevNoise = noise;
      if (j <= last) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Start an overflow sequence, assert reset mid-WAIT, and confirm nothing completes.
  task automatic resetMidWait();
    excOverflow = 1'b1;
    pcIn        = 32'h0000_2000;
    memAck      = 1'b0;
    @(posedge clk); #1;
    excOverflow = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("rst.pre_iordmux", 32'(iordmux), 32'd4);
    #2 reset = 1'b0;
    #1;
    checkIdleOutputs("rst.async");
    checkOutput("rst.epc_out", epcOut, 32'd0);
    checkOutput("rst.pc_next", pcNext, 32'd0);
`ifdef EXC_CAUSE_EN
    checkOutput("rst.exc_cause", 32'(excCause), 32'd0);
`endif
    memAck = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      checkOutput("rst.held_pc_load", 32'(pcLoad), 32'd0);
      checkOutput("rst.held_busy",    32'(busy),   32'd0);
    end
    @(negedge clk);
    reset  = 1'b1;
    memAck = 1'b0;
    @(posedge clk); #1;
  endtask

  // Directed test-plan cases, then random sequences.
  initial begin
    reset       = 1'b0;
    excOpcode   = 1'b0;
    excOverflow = 1'b0;
    excDivzero  = 1'b0;
    pcIn        = 32'd0;
    memRdata    = 32'd0;
    memAck      = 1'b0;
    #3;
    checkIdleOutputs("reset");
    checkOutput("reset.epc_out", epcOut, 32'd0);
    checkOutput("reset.pc_next", pcNext, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    $display("[TB] overflow, ack in third WAIT cycle");
    applyStimulus(3'b010, 32'h0000_0040, 32'h0000_00A7, 3, 1'b0);
    $display("[TB] opcode and divzero together");
    applyStimulus(3'b101, 32'h0000_1000, 32'hFFFF_FF12, 1, 1'b0);
    $display("[TB] divzero with pc_in of zero");
    applyStimulus(3'b001, 32'h0000_0000, 32'h1234_5655, 2, 1'b0);
    $display("[TB] no ack, timeout");
    applyStimulus(3'b010, 32'h0000_0800, 32'h0000_0033, ACK_TO + 1, 1'b0);
    $display("[TB] ack on the last allowed WAIT cycle");
    applyStimulus(3'b100, 32'h0000_0104, 32'h0000_00C3, ACK_TO, 1'b0);
    $display("[TB] reset during WAIT");
    resetMidWait();
    applyStimulus(3'b010, 32'h0000_0040, 32'h0000_00A7, 1, 1'b0);
    $display("[TB] events while busy are ignored");
    applyStimulus(3'b010, 32'h0000_0300, 32'h0000_0081, 4, 1'b1);

    $display("[TB] random sequences");
    for (int n = 0; n < 40; n++) begin
      applyStimulus(3'($urandom_range(1, 7)), $urandom, $urandom,
                    int'($urandom_range(1, ACK_TO + 2)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_vector_fetch.md
# exc_vector_fetch

Exception-entry sequencer for the multicycle CPU datapath. On an opcode, overflow or divide-by-zero event it saves EPC, then reads the exception vector by driving the memory-address select to one of the fixed vector slots (253/254/255) and completing a request/acknowledge read. It loads the zero-extended vector byte into PC. It sits between the control unit and the memory/PC path and is the only agent that drives the vector select codes 3'b011–3'b101.

## Interface
- ACK_TIMEOUT, 15 — max cycles spent in WAIT before forced abort (1..255)
- FALLBACK_PC, 32'd0 — PC loaded on timeout
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- exc_opcode  in  1  invalid-opcode event, sampled in IDLE
- exc_overflow  in  1  arithmetic overflow event, sampled in IDLE
- exc_divzero  in  1  divide-by-zero event, sampled in IDLE
- pc_in  in  32  current PC (already incremented by fetch)
- mem_rdata  in  32  memory read data, valid when mem_ack=1
- mem_ack  in  1  memory read complete
- iordmux  out  3  address select: 000 normal, 011 opcode slot, 100 overflow slot, 101 div-zero slot
- mem_req  out  1  read request, held until ack
- epc_write  out  1  one-cycle EPC write strobe
- epc_out  out  32  EPC value, valid with epc_write
- pc_load  out  1  one-cycle PC write strobe
- pc_next  out  32  new PC, valid with pc_load
- busy  out  1  sequencer not in IDLE; control unit stalls
- timeout  out  1  one-cycle pulse on ACK_TIMEOUT abort

## Operation
- States: IDLE, SAVE, REQ, WAIT, LOAD.
- IDLE: if any exc_* is high at a clock edge, latch the cause and go to SAVE. Priority: opcode > overflow > divzero. Lower-priority simultaneous events are dropped.
- SAVE: epc_write=1, epc_out=pc_in−4 (mod 2^32); go to REQ.
- REQ: mem_req=1, iordmux=cause code; go to WAIT.
- WAIT: mem_req=1, iordmux held. Count cycles.
  - On mem_ack=1, capture {24'b0, mem_rdata[7:0]} and go to LOAD.
  - If the count reaches ACK_TIMEOUT without ack, capture FALLBACK_PC, pulse timeout and go to LOAD.
- LOAD: pc_load=1, pc_next=captured value; go to IDLE.
- exc_* inputs are ignored while busy=1; no nesting or queuing.
- mem_ack outside REQ/WAIT is ignored.
- iordmux=000, mem_req=0 in IDLE/SAVE/LOAD.

## Timing
- Reset (async, reset=0): state=IDLE, all strobes 0, iordmux=000, epc_out=0, pc_next=0, busy=0, timeout=0, counter=0. Reset in any state aborts immediately; no PC/EPC write completes.
- Event seen at edge T0: SAVE during cycle T0+1 (epc_write), REQ during T0+2, WAIT from T0+3.
- Ack arriving during WAIT cycle k (first WAIT cycle k=1): pc_load in the following cycle. Minimum event-to-pc_load latency is 4 cycles.
- mem_ack during REQ is not sampled; memory must hold mem_ack until it sees mem_req with a WAIT-state sample, i.e. ack is level-valid while mem_req=1.
- busy=1 from T0+1 through the LOAD cycle inclusive.
- The event may be re-asserted on the cycle after LOAD (IDLE) and starts a new sequence.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

## Configuration
- EXC_CAUSE_EN defined: adds output exc_cause[1:0] (01 opcode, 10 overflow, 11 divzero, 00 none). It is loaded at SAVE and holds until the next exception or reset (reset value 00). Adds output exc_lost, a one-cycle pulse when an exc_* input is high while busy=1.
- Undefined: neither port exists; behaviour is otherwise identical.

## Test plan
- Overflow, pc_in=32'h0000_0040, ack after 2 WAIT cycles with mem_rdata=32'h0000_00A7 -> epc_out=32'h3C with epc_write, iordmux=100 during REQ/WAIT, pc_next=32'h0000_00A7 with pc_load 6 cycles after the event.
- Simultaneous opcode+divzero, mem_rdata=32'hFFFF_FF12 -> iordmux=011, pc_next=32'h12, the divzero event is dropped (exc_cause=01 and one exc_lost pulse not expected here; exc_lost fires only while busy).
- Divzero, pc_in=0 -> epc_out=32'hFFFF_FFFC (wrap), iordmux=101.
- No ack, ACK_TIMEOUT=15 -> timeout pulse, pc_next=FALLBACK_PC, busy drops after LOAD, iordmux returns to 000.
- reset low during WAIT -> outputs at reset values asynchronously, no pc_load; after release, a new overflow sequence completes normally.
- Overflow pulse while busy -> ignored; with EXC_CAUSE_EN, exc_lost=1 for that cycle and exc_cause unchanged.
